mole_sequencer: RTL and testbench
=================================

// Module: mole_sequencer
// PURPOSE
//  Game-round sequencer for the whack-a-mole design. It times the gap and on-window for each mole.
//  It picks the lit mole from a seeded LFSR and drives the one-hot light vector.
//  It scores keypad hits against the lit mole and decides game over for normal, timed and deathmatch modes.
//  It sits between the top-level setup FSM and the LED/keypad controllers.
// PARAMETERS
//  NUM_MOLES    9               number of lights/keys; mole index range 0..NUM_MOLES-1
//  CNT_W        28              width of time_on/time_between phase counters
//  GAME_CYCLES  32'd2999999999  timed-mode game length minus 1 (60 s at 50 MHz)
// PORTS
//  clk          in   1         system clock (CLOCK_50); the block's only clock
//  reset        in   1         asynchronous, active-low reset
//  load_seed    in   1         capture seed into LFSR; honoured in IDLE only
//  seed         in   8         LFSR seed; 8'h00 is replaced by 8'h01
//  start        in   1         level; rising into IDLE/DONE starts a game
//  mode         in   4         one-hot: 0001 normal, 0010 timed, 0100 deathmatch, other = normal
//  time_on      in   CNT_W     on-window length minus 1, in cycles
//  time_between in   CNT_W     gap length minus 1, in cycles
//  max_hits     in   6         number of flicks per game (normal/deathmatch)
//  hit_valid    in   1         single-cycle keypress strobe from keypad_controller
//  hit_idx      in   4         key index accompanying hit_valid
//  lights       out  NUM_MOLES one-hot lit mole; all zero outside ON
//  points       out  6         hits this game, saturating at 63
//  flicks       out  6         moles shown this game
//  busy         out  1         high in GAP/ON
//  game_over    out  1         high in DONE
// BEHAVIOUR
//  - Reset: state IDLE, lfsr=8'h01; lights, points, flicks, busy and game_over all 0; counters 0.
//  - States IDLE, GAP, ON, DONE. start is edge-detected with a registered copy, so holding start high does not restart the game.
//  - IDLE/DONE + start rise -> GAP next cycle. On that transition: points=0, flicks=0, phase_cnt=time_between, game_tmr=GAME_CYCLES.
//    mode, max_hits and seed are latched on the same edge.
//  - If max_hits==0 in a non-timed mode, the game goes from IDLE to DONE directly.
//  - GAP: phase_cnt decrements each cycle. At 0 (after time_between+1 cycles) the FSM goes to ON.
//    On that edge: lfsr steps, mole=lfsr[3:0] mod NUM_MOLES, lights=1<<mole, flicks+=1, phase_cnt=time_on.
//  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting left. It advances once per flick only.
//  - ON: a hit is hit_valid && hit_idx==mole.
//    On a hit: points+=1 (saturating), lights=0, go to GAP with phase_cnt=time_between. The LED goes dark the cycle after the strobe.
//  - ON: hit_valid with the wrong index is ignored. hit_valid outside ON is ignored.
//  - ON: timeout (phase_cnt==0 with no hit) is a miss: lights=0, go to GAP.
//  - Hit in the same cycle as timeout: the hit wins and is scored.
//  - End (normal/deathmatch): the game goes to DONE instead of GAP on the edge that leaves ON, when flicks==max_hits. The final hit still scores.
//  - Timed mode: game_tmr decrements in GAP/ON and the flick limit is ignored.
//    At game_tmr==0 the FSM goes to DONE from either state and lights=0. A hit in that same cycle still scores.
//  - DONE: points and flicks hold; game_over=1.
//  - reset low mid-game aborts asynchronously to IDLE with outputs cleared; a hit in progress is lost.
//  - time_on/time_between are sampled only when a phase counter loads; changes mid-phase take effect at the next phase.
// CONFIGURATION
//  DEATHMATCH_EN defined: in deathmatch mode, the first ON timeout goes to DONE with lights=0. Points are kept.
//  DEATHMATCH_EN undefined: the 0100 mode decodes as normal; no early end.
// STRUCTURE
//  Shared package (wam_pkg): state encodings, mode one-hot constants, LFSR tap mask, NUM_MOLES.
//  Sub-module mole_lfsr: seed load, step enable, mole index output with the mod-NUM_MOLES fold.
//  The FSM, counters and scoring live in mole_sequencer.
// TESTING
//  1 Reset mid-ON (time_on=20, reset low at cycle 5) -> lights=0, points=0, state IDLE, async within the cycle.
//  2 Normal, time_between=3, time_on=9, max_hits=3, correct hit 2 cycles into each ON.
//    -> first light 4 cycles after start; points=3, flicks=3; game_over the cycle after the 3rd hit.
//  3 Wrong hit_idx during ON, then no hit -> points unchanged; lights clear after exactly 10 ON cycles.
//  4 Correct hit in the last ON cycle (phase_cnt==0) -> scored (points+1), not a miss.
//  5 Timed, GAME_CYCLES=50, time_on=time_between=4, max_hits=1 -> DONE at cycle 51, flicks>1, lights=0.
//  6 DEATHMATCH_EN, mode=0100, one hit then a timeout -> game_over=1, points=1, flicks=2; without the macro, play continues to max_hits.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole round logic: FSM states,
// one-hot mode codes, LFSR tap mask and the default mole count.
package wam_pkg;

  localparam int unsigned NUM_MOLES = 9;

  // Fibonacci taps 8,6,5,4 -> register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Any mode code other than these plays as normal
  localparam logic [3:0] MODE_TIMED = 4'b0010;
  localparam logic [3:0] MODE_DEATH = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    ON,
    DONE
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Seeded 8-bit LFSR that picks the next lit mole. next_mole is the index
// that becomes current when step is asserted (derived from the stepped value).
module mole_lfsr #(
  parameter int unsigned NUM_MOLES = wam_pkg::NUM_MOLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [3:0] next_mole
);
  import wam_pkg::*;

  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;

  assign lfsr_nxt  = lfsr_next(lfsr);
  assign next_mole = lfsr_nxt[3:0] % 4'(NUM_MOLES);

  // Seed load takes priority over stepping; an all-zero seed would lock up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 8'h01;
    end else if (load) begin
      lfsr <= (seed == '0) ? 8'h01 : seed;
    end else if (step) begin
      lfsr <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/mole_sequencer.sv
// Whack-a-mole round sequencer: gap/on-window timing, mole selection,
// hit scoring and game-over for normal, timed and deathmatch modes.
// Optional feature macro: DEATHMATCH_EN (deathmatch ends on first miss).
module mole_sequencer #(
  parameter int unsigned NUM_MOLES   = wam_pkg::NUM_MOLES,
  parameter int unsigned CNT_W       = 28,
  parameter logic [31:0] GAME_CYCLES = 32'd2999999999
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_seed,
  input  logic [7:0]           seed,
  input  logic                 start,
  input  logic [3:0]           mode,
  input  logic [CNT_W-1:0]     time_on,
  input  logic [CNT_W-1:0]     time_between,
  input  logic [5:0]           max_hits,
  input  logic                 hit_valid,
  input  logic [3:0]           hit_idx,
  output logic [NUM_MOLES-1:0] lights,
  output logic [5:0]           points,
  output logic [5:0]           flicks,
  output logic                 busy,
  output logic                 game_over
);
  import wam_pkg::*;

  state_t               state, state_n;
  logic                 start_q;
  logic [3:0]           mode_q, mode_n;
  logic [5:0]           max_q, max_n;
  logic [CNT_W-1:0]     phase, phase_n;
  logic [31:0]          tmr, tmr_n;
  logic [5:0]           points_n, flicks_n;
  logic [NUM_MOLES-1:0] lights_n;
  logic [3:0]           mole, mole_n;
  logic [3:0]           next_mole;
  logic                 load, step;
  logic                 start_rise, timed, death, hit, tmr_end;

  assign start_rise = start && !start_q;
  assign timed      = (mode_q == MODE_TIMED);
  assign hit        = hit_valid && (hit_idx == mole);
  assign tmr_end    = timed && (tmr == '0);
  assign busy       = (state == GAP) || (state == ON);
  assign game_over  = (state == DONE);

`ifdef DEATHMATCH_EN
  assign death = (mode_q == MODE_DEATH);
`else
  assign death = 1'b0;
`endif

  mole_lfsr #(
    .NUM_MOLES(NUM_MOLES)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .seed     (seed),
    .next_mole(next_mole)
  );

  // State, counters and score registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      mode_q  <= '0;
      max_q   <= '0;
      phase   <= '0;
      tmr     <= '0;
      points  <= '0;
      flicks  <= '0;
      lights  <= '0;
      mole    <= '0;
    end else begin
      state   <= state_n;
      start_q <= start;
      mode_q  <= mode_n;
      max_q   <= max_n;
      phase   <= phase_n;
      tmr     <= tmr_n;
      points  <= points_n;
      flicks  <= flicks_n;
      lights  <= lights_n;
      mole    <= mole_n;
    end
  end

  // Next-state, phase timing, scoring and end-of-game decisions
  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    max_n    = max_q;
    phase_n  = phase;
    tmr_n    = tmr;
    points_n = points;
    flicks_n = flicks;
    lights_n = lights;
    mole_n   = mole;
    step     = 1'b0;
    load     = load_seed && (state == IDLE);
    unique case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          load     = 1'b1;
          mode_n   = mode;
          max_n    = max_hits;
          points_n = '0;
          flicks_n = '0;
          phase_n  = time_between;
          tmr_n    = GAME_CYCLES;
          // The zero-flick check uses the live inputs: latched copies land this edge
          state_n  = (mode != MODE_TIMED && max_hits == '0) ? DONE : GAP;
        end
      end
      GAP: begin
        if (timed && tmr != '0) tmr_n = tmr - 1'b1;
        if (tmr_end) begin
          state_n = DONE;
        end else if (phase == '0) begin
          step     = 1'b1;
          mole_n   = next_mole;
          lights_n = NUM_MOLES'(1) << next_mole;
          flicks_n = flicks + 1'b1;
          phase_n  = time_on;
          state_n  = ON;
        end else begin
          phase_n = phase - 1'b1;
        end
      end
      ON: begin
        if (timed && tmr != '0) tmr_n = tmr - 1'b1;
        if (hit && points != '1) points_n = points + 1'b1;
        if (hit || phase == '0 || tmr_end) begin
          lights_n = '0;
          phase_n  = time_between;
          if (tmr_end)                       state_n = DONE;
          else if (!timed && flicks == max_q) state_n = DONE;
          else if (death && !hit)             state_n = DONE;
          else                                state_n = GAP;
        end else begin
          phase_n = phase - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mole_sequencer.sv
// Self-checking bench for mole_sequencer: predicted mole sequence is queued
// at game start and consumed each time a light comes on.
module tb_mole_sequencer;
  localparam int unsigned NM = 9;
  localparam int unsigned CW = 28;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_seed = 1'b0;
  logic [7:0]    seed = '0;
  logic          start = 1'b0;
  logic [3:0]    mode = '0;
  logic [CW-1:0] time_on = '0;
  logic [CW-1:0] time_between = '0;
  logic [5:0]    max_hits = '0;
  logic          hit_valid = 1'b0;
  logic [3:0]    hit_idx = '0;
  logic [NM-1:0] lights;
  logic [5:0]    points;
  logic [5:0]    flicks;
  logic          busy;
  logic          game_over;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mpts = 0;
  int mole_cur = 0;

  always #5 clk = ~clk;

  mole_sequencer #(
    .NUM_MOLES  (NM),
    .CNT_W      (CW),
    .GAME_CYCLES(32'd50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_seed   (load_seed),
    .seed        (seed),
    .start       (start),
    .mode        (mode),
    .time_on     (time_on),
    .time_between(time_between),
    .max_hits    (max_hits),
    .hit_valid   (hit_valid),
    .hit_idx     (hit_idx),
    .lights      (lights),
    .points      (points),
    .flicks      (flicks),
    .busy        (busy),
    .game_over   (game_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Drive a start pulse and queue the predicted mole indices for nflick flicks
  task automatic start_game(input logic [3:0] m, input int mh, input logic [7:0] sd,
                            input int ton, input int tbw, input int nflick);
    logic [7:0] l;
    exp_q.delete();
    mpts = 0;
    l = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < nflick; i++) begin
      l = ref_step(l);
      exp_q.push_back(int'(l[3:0]) % NM);
    end
    @(negedge clk);
    mode = m; max_hits = 6'(mh); seed = sd;
    time_on = CW'(ton); time_between = CW'(tbw); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the next light, check gap latency and the lit mole
  task automatic wait_light(input string tag, input int lat);
    int n;
    n = 0;
    while (lights == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, lat);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      mole_cur = exp_q.pop_front();
      check({tag, "_light"}, int'(lights), 1 << mole_cur);
    end
  endtask

  // act: 0 miss, 1 correct hit on lit cycle 'at', 2 wrong key then miss
  task automatic play_flick(input string tag, input int act, input int at,
                            input int ton, input int tbw);
    int lit;
    wait_light(tag, tbw + 1);
    lit = 1;
    if (act == 1) begin
      while (lit < at) begin
        @(negedge clk);
        lit++;
      end
      hit_valid = 1'b1;
      hit_idx   = 4'(mole_cur);
      @(negedge clk);
      hit_valid = 1'b0;
      mpts++;
      check({tag, "_dark"}, int'(lights), 0);
    end else begin
      while (lights != '0 && lit < 100) begin
        if (act == 2 && lit == 2) begin
          hit_valid = 1'b1;
          hit_idx   = 4'((mole_cur + 1) % NM);
        end
        @(negedge clk);
        hit_valid = 1'b0;
        if (lights != '0) lit++;
      end
      check({tag, "_on_len"}, lit, ton + 1);
    end
    check({tag, "_pts"}, int'(points), mpts);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_lights", int'(lights), 0);
    check("rst_points", int'(points), 0);
    check("rst_flicks", int'(flicks), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_over", int'(game_over), 0);

    // Normal game, three correct hits
    start_game(4'b0001, 3, 8'h5A, 9, 3, 3);
    check("n_busy", int'(busy), 1);
    play_flick("n1", 1, 2, 9, 3);
    play_flick("n2", 1, 2, 9, 3);
    play_flick("n3", 1, 2, 9, 3);
    check("n_over", int'(game_over), 1);
    check("n_points", int'(points), 3);
    check("n_flicks", int'(flicks), 3);
    check("n_busy_end", int'(busy), 0);

    // Wrong key then timeout, last-cycle hit, plain miss; zero seed
    start_game(4'b0001, 3, 8'h00, 9, 3, 3);
    play_flick("w1", 2, 0, 9, 3);
    play_flick("w2", 1, 10, 9, 3);
    play_flick("w3", 0, 0, 9, 3);
    check("w_over", int'(game_over), 1);
    check("w_points", int'(points), 1);
    check("w_flicks", int'(flicks), 3);

    // Zero flicks in normal mode ends immediately
    start_game(4'b0001, 0, 8'h11, 9, 3, 0);
    check("z_over", int'(game_over), 1);
    check("z_flicks", int'(flicks), 0);

    // Asynchronous reset in the middle of an ON window
    start_game(4'b0001, 5, 8'h33, 20, 3, 5);
    play_flick("r1", 1, 2, 20, 3);
    wait_light("r2", 4);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("ar_lights", int'(lights), 0);
    check("ar_points", int'(points), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_over", int'(game_over), 0);
    @(negedge clk);
    reset = 1'b1;

    // Timed game: flick limit ignored, ends on the game timer
    start_game(4'b0010, 1, 8'hC3, 4, 4, 0);
    n = 0;
    while (!game_over && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t_len", n, 51);
    check("t_lights", int'(lights), 0);
    check("t_flicks", int'(flicks), 5);
    check("t_points", int'(points), 0);

    // Deathmatch: one hit, then a timeout
    start_game(4'b0100, 3, 8'h77, 9, 3, 3);
    play_flick("d1", 1, 3, 9, 3);
    play_flick("d2", 0, 0, 9, 3);
`ifdef DEATHMATCH_EN
    check("d_over", int'(game_over), 1);
    check("d_points", int'(points), 1);
    check("d_flicks", int'(flicks), 2);
`else
    check("d_over_early", int'(game_over), 0);
    play_flick("d3", 1, 2, 9, 3);
    check("d_over", int'(game_over), 1);
    check("d_points", int'(points), 2);
    check("d_flicks", int'(flicks), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
